// File: rtl/baby_kyber_pkg.sv
// Shared constants, state encoding and modular helpers for the Baby-Kyber decrypt core.
package baby_kyber_pkg;

  localparam int DEF_Q  = 17;
  localparam int DEF_N  = 4;
  localparam int DEF_K  = 2;
  localparam int DEF_CW = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_DECODE,
    ST_DONE
  } state_t;

  function automatic int ceil_log2(input int v);
    int r;
    r = 0;
    for (int b = 0; b < 31; b++) begin
      if ((1 << b) < v) r = b + 1;
    end
    return r;
  endfunction

  function automatic int dec_lo(input int q);
    return (q + 3) / 4;
  endfunction

  function automatic int dec_hi(input int q);
    return (3 * q + 3) / 4;
  endfunction

  // True modulo: negative inputs land in [0,q) rather than (-q,0].
  function automatic int mod_q(input int x, input int q);
    int r;
    r = x % q;
    if (r < 0) r = r + q;
    return r;
  endfunction

endpackage

// File: rtl/baby_kyber_modq_mac.sv
// Combinational modular multiply-accumulate: res = (acc +/- a*b) mod Q, operands already in [0,Q).
module modq_mac
  import baby_kyber_pkg::*;
#(
  parameter int Q  = DEF_Q,
  parameter int QW = ceil_log2(Q)
) (
  input  logic [QW-1:0] acc,
  input  logic [QW-1:0] a,
  input  logic [QW-1:0] b,
  input  logic          sub,
  output logic [QW-1:0] res
);

  localparam int PW = 2 * QW;

  logic [PW-1:0] prod;
  logic [PW-1:0] p_mod;
  logic [PW-1:0] acc_w;
  logic [PW-1:0] sum;
  logic [PW-1:0] wrapped;

  assign prod  = PW'(a) * PW'(b);
  assign p_mod = prod % PW'(Q);
  assign acc_w = PW'(acc);

  // Both acc and p_mod are below Q, so one conditional correction suffices either way.
  always_comb begin
    sum     = '0;
    wrapped = '0;
    if (sub) sum = (acc_w >= p_mod) ? (acc_w - p_mod) : (acc_w + PW'(Q) - p_mod);
    else     sum = acc_w + p_mod;
    wrapped = (sum >= PW'(Q)) ? (sum - PW'(Q)) : sum;
    res     = QW'(wrapped);
  end

endmodule

// File: rtl/baby_kyber_decrypt_core.sv
// Sequential Baby-Kyber decryption: m = Decode(v - s^T.u) over Z_Q[x]/(x^N+1),
// using one time-multiplexed modular MAC and valid/ready handshakes.
module baby_kyber_decrypt_core
  import baby_kyber_pkg::*;
#(
  parameter int Q  = DEF_Q,
  parameter int N  = DEF_N,
  parameter int K  = DEF_K,
  parameter int CW = DEF_CW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [CW-1:0] secret_key [K][N],
  input  logic signed [CW-1:0] ct_u       [K][N],
  input  logic signed [CW-1:0] ct_v       [N],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         m_bits,
  output logic                 busy
);

  localparam int QW = ceil_log2(Q);
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int LO = dec_lo(Q);
  localparam int HI = dec_hi(Q);

  state_t state_q, state_d;

  logic signed [CW-1:0] sk_raw [K][N];
  logic signed [CW-1:0] u_raw  [K][N];
  logic signed [CW-1:0] v_raw  [N];
  logic [QW-1:0]        s_red  [K][N];
  logic [QW-1:0]        u_red  [K][N];
  logic [QW-1:0]        v_red  [N];
  logic [QW-1:0]        acc    [N];

  logic [KW-1:0] ci;
  logic [NW-1:0] cj, ck;
  logic [NW:0]   t_sum;
  logic          wrap;
  logic [NW-1:0] tgt;
  logic          mac_last;
  logic [QW-1:0] mac_res;
  logic [QW:0]   diff;
  logic [N-1:0]  dec_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = ST_LOAD;
      end
      ST_LOAD:   state_d = ST_MAC;
      ST_MAC:    if (mac_last) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Product index t = j+k; indices at or beyond N fold back negated since x^N = -1.
  assign t_sum    = {1'b0, cj} + {1'b0, ck};
  assign wrap     = (t_sum >= (NW+1)'(N));
  assign tgt      = wrap ? NW'(t_sum - (NW+1)'(N)) : NW'(t_sum);
  assign mac_last = (ci == KW'(K-1)) && (cj == NW'(N-1)) && (ck == NW'(N-1));

  modq_mac #(.Q(Q), .QW(QW)) u_mac (
    .acc (acc[tgt]),
    .a   (s_red[ci][cj]),
    .b   (u_red[ci][ck]),
    .sub (wrap),
    .res (mac_res)
  );

  always_comb begin
    dec_bits = '0;
    diff     = '0;
    for (int i = 0; i < N; i++) begin
      if (v_red[i] >= acc[i]) diff = {1'b0, v_red[i]} - {1'b0, acc[i]};
      else                    diff = {1'b0, v_red[i]} + (QW+1)'(Q) - {1'b0, acc[i]};
      dec_bits[N-1-i] = (diff >= (QW+1)'(LO)) && (diff <= (QW+1)'(HI));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < N; j++) begin
          sk_raw[i][j] <= '0;
          u_raw[i][j]  <= '0;
          s_red[i][j]  <= '0;
          u_red[i][j]  <= '0;
        end
      end
      for (int j = 0; j < N; j++) begin
        v_raw[j] <= '0;
        v_red[j] <= '0;
        acc[j]   <= '0;
      end
      ci     <= '0;
      cj     <= '0;
      ck     <= '0;
      m_bits <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            sk_raw <= secret_key;
            u_raw  <= ct_u;
            v_raw  <= ct_v;
          end
        end
        ST_LOAD: begin
          for (int i = 0; i < K; i++) begin
            for (int j = 0; j < N; j++) begin
              s_red[i][j] <= QW'(mod_q(int'(sk_raw[i][j]), Q));
              u_red[i][j] <= QW'(mod_q(int'(u_raw[i][j]), Q));
            end
          end
          for (int j = 0; j < N; j++) begin
            v_red[j] <= QW'(mod_q(int'(v_raw[j]), Q));
            acc[j]   <= '0;
          end
          ci <= '0;
          cj <= '0;
          ck <= '0;
        end
        ST_MAC: begin
          acc[tgt] <= mac_res;
          if (ck == NW'(N-1)) begin
            ck <= '0;
            if (cj == NW'(N-1)) begin
              cj <= '0;
              ci <= (ci == KW'(K-1)) ? '0 : ci + KW'(1);
            end else begin
              cj <= cj + NW'(1);
            end
          end else begin
            ck <= ck + NW'(1);
          end
        end
        ST_DECODE: m_bits <= dec_bits;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_baby_kyber_decrypt_core.sv
// Randomised and directed bench for baby_kyber_decrypt_core with a queue scoreboard and ring-arithmetic model.
module tb_baby_kyber_decrypt_core;

  localparam int Q   = 17;
  localparam int N   = 4;
  localparam int K   = 2;
  localparam int CW  = 32;
  localparam int LAT = K * N * N + 2;
  localparam int LO  = (Q + 3) / 4;
  localparam int HI  = (3 * Q + 3) / 4;

  typedef struct {
    logic [N-1:0] bits;
    int           hs;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [CW-1:0] secret_key [K][N];
  logic signed [CW-1:0] ct_u       [K][N];
  logic signed [CW-1:0] ct_v       [N];
  logic                 out_valid;
  logic                 out_ready;
  logic [N-1:0]         m_bits;
  logic                 busy;

  int   s_m [K][N];
  int   u_m [K][N];
  int   v_m [N];
  exp_t sb[$];
  int   checks;
  int   errors;
  int   cycle;
  bit   seen;

  baby_kyber_decrypt_core #(.Q(Q), .N(N), .K(K), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .secret_key (secret_key),
    .ct_u       (ct_u),
    .ct_v       (ct_v),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .m_bits     (m_bits),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic int modQ(input int a);
    return ((a % Q) + Q) % Q;
  endfunction

  // Schoolbook product in Z[x] with x^N = -1, reduced only at the end.
  function automatic logic [N-1:0] refModel();
    int acc [N];
    int x;
    logic [N-1:0] r;
    r = '0;
    for (int t = 0; t < N; t++) acc[t] = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < N; k++) begin
          if (j + k < N) acc[j+k]   = acc[j+k]   + s_m[i][j] * u_m[i][k];
          else           acc[j+k-N] = acc[j+k-N] - s_m[i][j] * u_m[i][k];
        end
    for (int t = 0; t < N; t++) begin
      x = modQ(v_m[t] - acc[t]);
      r[N-1-t] = (x >= LO) && (x <= HI);
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic clearOperands();
    for (int i = 0; i < K; i++)
      for (int j = 0; j < N; j++) begin
        s_m[i][j] = 0;
        u_m[i][j] = 0;
      end
    for (int j = 0; j < N; j++) v_m[j] = 0;
  endtask

  task automatic randomOperands();
    for (int i = 0; i < K; i++)
      for (int j = 0; j < N; j++) begin
        s_m[i][j] = int'($urandom_range(0, 60)) - 30;
        u_m[i][j] = int'($urandom_range(0, 60)) - 30;
      end
    for (int j = 0; j < N; j++) v_m[j] = int'($urandom_range(0, 60)) - 30;
  endtask

  task automatic applyStimulus();
    bit   hs;
    bit   got;
    exp_t e;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < N; j++) begin
        secret_key[i][j] = s_m[i][j];
        ct_u[i][j]       = u_m[i][j];
      end
    for (int j = 0; j < N; j++) ct_v[j] = v_m[j];
    in_valid = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      hs = in_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        got = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    checkOutput("accept_handshake", 32'(got), 32'd1);
    if (got) begin
      checkOutput("busy_after_accept", 32'(busy), 32'd1);
      checkOutput("in_ready_after_accept", 32'(in_ready), 32'd0);
      e.bits = refModel();
      e.hs   = cycle;
      sb.push_back(e);
    end
  endtask

  task automatic drainScoreboard();
    for (int c = 0; c < 400; c++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    checkOutput("drain_scoreboard", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compares every presented result against the oldest pending expectation.
  initial begin
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          if (!seen) begin
            checkOutput("latency", 32'(cycle - sb[0].hs), 32'(LAT));
            seen = 1'b1;
          end
          checkOutput("m_bits", 32'(m_bits), 32'(sb[0].bits));
          checkOutput("in_ready_in_done", 32'(in_ready), 32'd0);
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached with %0d results pending", sb.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N-1:0] held;
    bit got;
    checks    = 0;
    errors    = 0;
    cycle     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clearOperands();
    for (int i = 0; i < K; i++)
      for (int j = 0; j < N; j++) begin
        secret_key[i][j] = '0;
        ct_u[i][j]       = '0;
      end
    for (int j = 0; j < N; j++) ct_v[j] = '0;

    #12;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_m_bits", 32'(m_bits), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] directed cases");
    clearOperands();
    v_m = '{9, 0, 9, 0};
    applyStimulus();
    clearOperands();
    v_m = '{4, 5, 13, 14};
    applyStimulus();
    clearOperands();
    s_m[0] = '{1, 0, 0, 0};
    u_m[0] = '{0, 0, 0, 8};
    applyStimulus();
    clearOperands();
    s_m[0] = '{0, 1, 0, 0};
    u_m[0] = '{0, 0, 0, 8};
    applyStimulus();
    clearOperands();
    v_m[0] = -8;
    s_m[0] = '{1, 0, 0, 0};
    s_m[1] = '{1, 0, 0, 0};
    u_m[0] = '{0, 3, 0, 0};
    u_m[1] = '{0, 2, 0, 0};
    applyStimulus();
    drainScoreboard();

    $display("[TB] backpressure");
    out_ready = 1'b0;
    clearOperands();
    v_m = '{9, 9, 0, 13};
    applyStimulus();
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("bp_reach_done", 32'(got), 32'd1);
    held = m_bits;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      for (int j = 0; j < N; j++) ct_v[j] = $urandom;
      @(posedge clk);
      #1;
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_m_bits_hold", 32'(m_bits), 32'(held));
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("in_ready_return", 32'(in_ready), 32'd1);
    checkOutput("out_valid_drop", 32'(out_valid), 32'd0);
    drainScoreboard();

    $display("[TB] reset during MAC");
    randomOperands();
    applyStimulus();
    repeat (11) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midmac_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midmac_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midmac_rst_busy", 32'(busy), 32'd0);
    checkOutput("midmac_rst_m_bits", 32'(m_bits), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clearOperands();
    v_m[0] = -8;
    s_m[0] = '{1, 0, 0, 0};
    s_m[1] = '{1, 0, 0, 0};
    u_m[0] = '{0, 3, 0, 0};
    u_m[1] = '{0, 2, 0, 0};
    applyStimulus();
    drainScoreboard();

    $display("[TB] random cases");
    for (int n = 0; n < 24; n++) begin
      randomOperands();
      applyStimulus();
    end
    drainScoreboard();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
